result_bcd_display: RTL and testbench

RESULT_BCD_DISPLAY -- requirements
Module: result_bcd_display

---
 rtl/result_bcd_display_pkg.sv | 38 +++
 rtl/result_bcd_display_bcd_digit_to_seg.sv | 33 +++
 rtl/result_bcd_display.sv | 154 +++++++++++++++
 tb/tb_result_bcd_display.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/result_bcd_display_pkg.sv
// Shared types and constants for the result BCD display: converter states,
// digit count, active-low segment patterns and the double-dabble adjust step.
package result_bcd_display_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } conv_state_e;

   localparam int NUM_DIGITS = 5;

   // Segment order {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
   function automatic logic [19:0] bcd_add3(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/result_bcd_display_bcd_digit_to_seg.sv
// Decodes one BCD digit to active-low segments; dash overrides blank,
// and blank overrides the digit value.
module bcd_digit_to_seg
   import result_bcd_display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/result_bcd_display.sv
// Converts a 16-bit ALU result to five BCD digits with an iterative
// double-dabble and scans them onto a multiplexed 7-segment display.
module result_bcd_display
   import result_bcd_display_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        in_flag,
   output logic        in_ready,
   output logic [19:0] bcd_out,
   output logic        bcd_valid,
   output logic        flag_latched,
   output logic [6:0]  seg,
   output logic [4:0]  an
);

   localparam logic [15:0] PRESC_MAX  = 16'(SCAN_DIV - 1);
   localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);

   conv_state_e state_q, state_d;
   logic [15:0] bin_q;
   logic [19:0] work_q;
   logic [3:0]  cnt_q;
   logic        flag_cap_q;
   logic [19:0] bcd_out_q;
   logic        flag_q;
   logic        valid_q;
   logic [15:0] presc_q;
   logic [2:0]  digit_q;

   logic        transfer;
   logic [19:0] adj;
   logic [35:0] dabble;

   assign transfer = in_valid && in_ready;
   assign adj      = bcd_add3(work_q);
   assign dabble   = {adj[18:0], bin_q, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (transfer) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == 4'd15) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_IDLE);
   end

   // Displayed result only changes on the final shift, so an abandoned
   // or in-flight conversion never disturbs bcd_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q      <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         flag_cap_q <= 1'b0;
         bcd_out_q  <= '0;
         flag_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (transfer) begin
            bin_q      <= in_data;
            flag_cap_q <= in_flag;
            work_q     <= '0;
            cnt_q      <= '0;
         end else if (state_q == ST_SHIFT) begin
            work_q <= dabble[35:16];
            bin_q  <= dabble[15:0];
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               bcd_out_q <= dabble[35:16];
               flag_q    <= flag_cap_q;
               valid_q   <= 1'b1;
            end
         end
      end
   end

   assign bcd_out      = bcd_out_q;
   assign bcd_valid    = valid_q;
   assign flag_latched = flag_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         digit_q <= '0;
      end else if (presc_q == PRESC_MAX) begin
         presc_q <= '0;
         digit_q <= (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
      end else begin
         presc_q <= presc_q + 16'd1;
      end
   end

   assign an = ~(5'b00001 << digit_q);

   logic [3:0] nib [NUM_DIGITS];
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib[gi] = bcd_out_q[gi*4 +: 4];
      end
   endgenerate

   // blank_vec[i] is set when digit i and every digit above it are zero.
   logic [4:0] blank_vec;
   logic       all_zero;
   always_comb begin
      blank_vec = '0;
      all_zero  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero     = all_zero && (nib[i] == 4'd0);
         blank_vec[i] = all_zero;
      end
   end

   logic [3:0] cur_nib;
   logic       cur_blank;
   always_comb begin
      cur_nib   = nib[0];
      cur_blank = 1'b0;
      case (digit_q)
         3'd1:    begin cur_nib = nib[1]; cur_blank = blank_vec[1]; end
         3'd2:    begin cur_nib = nib[2]; cur_blank = blank_vec[2]; end
         3'd3:    begin cur_nib = nib[3]; cur_blank = blank_vec[3]; end
         3'd4:    begin cur_nib = nib[4]; cur_blank = blank_vec[4]; end
         default: begin cur_nib = nib[0]; cur_blank = 1'b0; end
      endcase
   end

   bcd_digit_to_seg u_seg (
      .digit_i (cur_nib),
      .blank_i (cur_blank),
      .dash_i  (flag_q),
      .seg_o   (seg)
   );

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: conversion results, latency,
// busy handling, reset abort and the scanned segment output.
module tb_result_bcd_display;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_flag;
   logic        in_ready;
   logic [19:0] bcd_out;
   logic        bcd_valid;
   logic        flag_latched;
   logic [6:0]  seg;
   logic [4:0]  an;

   int total = 0;
   int bad   = 0;

   result_bcd_display #(.SCAN_DIV(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_flag      (in_flag),
      .in_ready     (in_ready),
      .bcd_out      (bcd_out),
      .bcd_valid    (bcd_valid),
      .flag_latched (flag_latched),
      .seg          (seg),
      .an           (an)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transfer one value and wait (bounded) for its result pulse.
   task automatic convert(input logic [15:0] d, input logic f, input logic [19:0] exp);
      int cyc;
      int low;
      in_valid = 1'b1;
      in_data  = d;
      in_flag  = f;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      low = 0;
      while (bcd_valid !== 1'b1 && cyc < 40) begin
         if (in_ready === 1'b0) low++;
         tick();
         cyc++;
      end
      $display("convert data=%0d flag=%0b -> bcd=%05h latency=%0d busy=%0d", d, f, bcd_out, cyc, low);
      chk("latency", cyc, 16);
      chk("ready_low_cycles", low, 16);
      chk("bcd_out", {12'd0, bcd_out}, {12'd0, exp});
      chk("flag_latched", {31'd0, flag_latched}, {31'd0, f});
      chk("ready_after_done", {31'd0, in_ready}, 32'd1);
      tick();
      chk("valid_one_cycle", {31'd0, bcd_valid}, 32'd0);
   endtask

   logic [4:0] exp_an  [5];
   logic [6:0] exp_seg [5];

   initial begin
      int pulses;
      logic [4:0] prev_an;
      int guard;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_flag  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      $display("reset: ready=%0b bcd=%05h an=%05b seg=%07b", in_ready, bcd_out, an, seg);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_bcd", {12'd0, bcd_out}, 32'd0);
      chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
      chk("rst_flag", {31'd0, flag_latched}, 32'd0);
      chk("rst_an", {27'd0, an}, 32'b11110);
      chk("rst_seg", {25'd0, seg}, 32'b1000000);

      convert(16'd12345, 1'b0, 20'h12345);
      convert(16'd65535, 1'b0, 20'h65535);
      convert(16'd0, 1'b0, 20'h00000);

      // Zero: only the units digit is lit.
      for (int i = 0; i < 20; i++) begin
         chk("zero_an_onehot", $countones(~an), 1);
         chk("zero_seg", {25'd0, seg}, (an == 5'b11110) ? 32'b1000000 : 32'b1111111);
         tick();
      end
      $display("zero display scan checked");

      convert(16'd40, 1'b1, 20'h00040);
      for (int i = 0; i < 20; i++) begin
         chk("dash_seg", {25'd0, seg}, 32'b0111111);
         tick();
      end
      $display("flagged display scan checked");

      convert(16'd707, 1'b0, 20'h00707);
      exp_an[0] = 5'b11110; exp_seg[0] = 7'b1111000;
      exp_an[1] = 5'b11101; exp_seg[1] = 7'b1000000;
      exp_an[2] = 5'b11011; exp_seg[2] = 7'b1111000;
      exp_an[3] = 5'b10111; exp_seg[3] = 7'b1111111;
      exp_an[4] = 5'b01111; exp_seg[4] = 7'b1111111;
      guard = 0;
      prev_an = an;
      tick();
      while (!(an == 5'b11110 && prev_an != 5'b11110) && guard < 30) begin
         prev_an = an;
         tick();
         guard++;
      end
      chk("scan_sync_found", {31'd0, guard < 30}, 32'd1);
      for (int d = 0; d < 5; d++) begin
         for (int k = 0; k < 4; k++) begin
            chk("scan707_an", {27'd0, an}, {27'd0, exp_an[d]});
            chk("scan707_seg", {25'd0, seg}, {25'd0, exp_seg[d]});
            tick();
         end
         $display("scan digit %0d an=%05b seg=%07b", d, exp_an[d], exp_seg[d]);
      end

      // A second request while busy is dropped.
      in_valid = 1'b1;
      in_data  = 16'd12345;
      in_flag  = 1'b0;
      tick();
      in_data = 16'd999;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 6) in_valid = 1'b0;
         if (i == 3) chk("busy_hold_bcd", {12'd0, bcd_out}, 32'h00707);
         if (bcd_valid === 1'b1) pulses++;
         tick();
      end
      $display("busy test: pulses=%0d bcd=%05h", pulses, bcd_out);
      chk("busy_pulses", pulses, 1);
      chk("busy_bcd", {12'd0, bcd_out}, 32'h12345);

      // Reset in the middle of a conversion.
      in_valid = 1'b1;
      in_data  = 16'd500;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("mid reset: ready=%0b bcd=%05h", in_ready, bcd_out);
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_bcd", {12'd0, bcd_out}, 32'd0);
      chk("abort_an", {27'd0, an}, 32'b11110);
      chk("abort_seg", {25'd0, seg}, 32'b1000000);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (bcd_valid === 1'b1) pulses++;
         tick();
      end
      chk("abort_no_pulse", pulses, 0);

      // Reset wins over a simultaneous transfer.
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd77;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_prio_ready", {31'd0, in_ready}, 32'd1);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         if (bcd_valid === 1'b1) pulses++;
         tick();
      end
      $display("reset priority: pulses=%0d bcd=%05h", pulses, bcd_out);
      chk("rst_prio_no_pulse", pulses, 0);
      chk("rst_prio_bcd", {12'd0, bcd_out}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
